id_ex_hazard_stage: RTL

- ID/EX pipeline register of the 5-stage MIPS pipeline, combined with load-use hazard detection and multi-cycle EX hold control.
- Latches decoded ID fields into the EX stage. Its ex_rs/ex_rt outputs feed the forwarding unit directly downstream.
- Inserts a one-cycle bubble on a load-use hazard, holds EX for multi-cycle multiplies, and squashes the ID instruction on a taken branch.
- Drives the PC and IF/ID write enables upstream.

---
 rtl/id_ex_hazard_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline. Besides latching the
// decoded ID fields into EX, it detects load-use hazards (one bubble each),
// holds EX while a multi-cycle multiply occupies it, squashes the ID
// instruction on a taken branch, and drives the PC and IF/ID write enables.
module id_ex_hazard_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int MUL_LAT = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [DATA_W-1:0] id_rs_val,
   input  logic [DATA_W-1:0] id_rt_val,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              id_memtoreg,
   input  logic              id_alusrc,
   input  logic [3:0]        id_aluop,
   input  logic              id_is_mul,
   input  logic              ex_flush,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ex_valid,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic [DATA_W-1:0] ex_rs_val,
   output logic [DATA_W-1:0] ex_rt_val,
   output logic [DATA_W-1:0] ex_imm,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_memtoreg,
   output logic              ex_alusrc,
   output logic [3:0]        ex_aluop,
   output logic              ex_busy
);

   localparam int CNT_W = $clog2(MUL_LAT) + 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

   // Everything the EX stage holds; an all-zero value is a bubble, so the
   // forwarding unit sees register 0 and never forwards from it.
   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] rsVal;
      logic [DATA_W-1:0] rtVal;
      logic [DATA_W-1:0] imm;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              memtoreg;
      logic              alusrc;
      logic [3:0]        aluop;
   } exReg_t;

   // What happens at the next edge, in decreasing priority.
   typedef enum logic [1:0] {
      ACT_FLUSH,
      ACT_HOLD,
      ACT_STALL,
      ACT_ADVANCE
   } action_t;

   exReg_t           exReg_q, exReg_d;
   logic [CNT_W-1:0] busyCnt_q, busyCnt_d;
   action_t          action;
   logic             loadUse;
   logic             busy;
   logic             upstreamWrite;

   // Decide this cycle's action and build the next EX contents and counter.
   // A held multiply only counts down; it never reloads the counter.
   always_comb begin
      exReg_d       = exReg_q;
      busyCnt_d     = busyCnt_q;
      upstreamWrite = 1'b1;
      busy          = (busyCnt_q != '0);
      loadUse       = id_valid & exReg_q.valid & exReg_q.memread &
                      (exReg_q.rt != '0) &
                      ((exReg_q.rt == id_rs) | (exReg_q.rt == id_rt));

      if (ex_flush) begin
         action = ACT_FLUSH;
      end else if (busy) begin
         action = ACT_HOLD;
      end else if (loadUse) begin
         action = ACT_STALL;
      end else begin
         action = ACT_ADVANCE;
      end

      unique case (action)
         ACT_FLUSH: begin
            exReg_d   = '0;
            busyCnt_d = '0;
         end
         ACT_HOLD: begin
            busyCnt_d     = busyCnt_q - 1'b1;
            upstreamWrite = 1'b0;
         end
         ACT_STALL: begin
            exReg_d       = '0;
            upstreamWrite = 1'b0;
         end
         ACT_ADVANCE: begin
            if (id_valid) begin
               exReg_d.valid    = 1'b1;
               exReg_d.rs       = id_rs;
               exReg_d.rt       = id_rt;
               exReg_d.rd       = id_rd;
               exReg_d.rsVal    = id_rs_val;
               exReg_d.rtVal    = id_rt_val;
               exReg_d.imm      = id_imm;
               exReg_d.regwrite = id_regwrite;
               exReg_d.memread  = id_memread;
               exReg_d.memwrite = id_memwrite;
               exReg_d.memtoreg = id_memtoreg;
               exReg_d.alusrc   = id_alusrc;
               exReg_d.aluop    = id_aluop;
               busyCnt_d        = id_is_mul ? MUL_LOAD : '0;
            end else begin
               exReg_d   = '0;
               busyCnt_d = '0;
            end
         end
      endcase
   end

   // ID/EX register and multiply busy counter; reset abandons any multiply.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exReg_q   <= '0;
         busyCnt_q <= '0;
      end else begin
         exReg_q   <= exReg_d;
         busyCnt_q <= busyCnt_d;
      end
   end

   assign pc_write    = upstreamWrite;
   assign ifid_write  = upstreamWrite;
   assign ex_busy     = busy;
   assign ex_valid    = exReg_q.valid;
   assign ex_rs       = exReg_q.rs;
   assign ex_rt       = exReg_q.rt;
   assign ex_rd       = exReg_q.rd;
   assign ex_rs_val   = exReg_q.rsVal;
   assign ex_rt_val   = exReg_q.rtVal;
   assign ex_imm      = exReg_q.imm;
   assign ex_regwrite = exReg_q.regwrite;
   assign ex_memread  = exReg_q.memread;
   assign ex_memwrite = exReg_q.memwrite;
   assign ex_memtoreg = exReg_q.memtoreg;
   assign ex_alusrc   = exReg_q.alusrc;
   assign ex_aluop    = exReg_q.aluop;

endmodule
